// File: rtl/bitserial_addsub.sv
// bitserial_addsub: LSB-first bit-serial adder/subtractor using one full-adder slice and a carry flip-flop.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset; aborts any operation in progress
//   start  - begin an operation (accepted only while idle)
//   sub    - 0 = A+B+Cin, 1 = A-B-Cin; sampled with start
//   A, B   - WIDTH-bit operands; sampled with start
//   Cin    - carry-in (add) or borrow-in (subtract); sampled with start
//   busy   - high from the accepting edge until the done cycle ends
//   done   - one-cycle pulse when sum/Cout/ovf take a new result
//   sum    - registered result, held until the next done
//   Cout   - raw carry out of the MSB stage (subtract: 1 = no borrow)
//   ovf    - two's-complement overflow of the last result
module bitserial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             Cout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    count;
    logic             s_bit;
    logic             c_next;

    assign s_bit  = op_a[0] ^ op_b[0] ^ carry;
    assign c_next = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            Cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    // subtraction is A + ~B + ~Cin
                    op_a  <= A;
                    op_b  <= sub ? ~B : B;
                    carry <= sub ? ~Cin : Cin;
                    count <= '0;
                    busy  <= 1'b1;
                    state <= SHIFT;
                end
                SHIFT: begin
                    acc   <= {s_bit, acc[WIDTH-1:1]};
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= c_next;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        // carry still holds the carry into the MSB here
                        sum   <= {s_bit, acc[WIDTH-1:1]};
                        Cout  <= c_next;
                        ovf   <= carry ^ c_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitserial_addsub.sv
// tb_bitserial_addsub: randomized and directed checks of bitserial_addsub (WIDTH=8 and WIDTH=4) against an arithmetic model.
module tb_bitserial_addsub;
    logic       clk = 0;
    logic       reset = 1;
    logic       start = 0, sub = 0, Cin = 0;
    logic [7:0] A = 0, B = 0;
    logic       busy, done, Cout, ovf;
    logic [7:0] sum;
    logic       start4 = 0, sub4 = 0, cin4 = 0;
    logic [3:0] a4 = 0, b4 = 0;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;
    int         n_cmp = 0, n_bad = 0;
    bit         chk_en = 0;
    int         m_rem = 0;
    logic [7:0] m_sum = 0, p_sum = 0;
    bit         m_cout = 0, m_ovf = 0, p_cout = 0, p_ovf = 0;
    longint     mr;
    bit         mco, mov;

    always #5 clk = ~clk;

    bitserial_addsub #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(start), .sub(sub), .A(A), .B(B), .Cin(Cin),
        .busy(busy), .done(done), .sum(sum), .Cout(Cout), .ovf(ovf)
    );

    bitserial_addsub #(.WIDTH(4)) u4 (
        .clk(clk), .reset(reset), .start(start4), .sub(sub4), .A(a4), .B(b4), .Cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .Cout(cout4), .ovf(ovf4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Result from plain integer arithmetic on unsigned and signed interpretations.
    function automatic void ref_calc(input int w, input longint a, input longint b, input bit s, input bit c,
                                     output longint r, output bit co, output bit ov);
        longint m, half, sa, sb, u, sv;
        m    = longint'(1) << w;
        half = m / 2;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        if (!s) begin
            u  = a + b + longint'(c);
            co = (u >= m);
            sv = sa + sb + longint'(c);
        end else begin
            u  = a - b - longint'(c);
            co = (a >= b + longint'(c));
            sv = sa - sb - longint'(c);
        end
        r  = ((u % m) + m) % m;
        ov = (sv >= half) || (sv < -half);
    endfunction

    // Model: accepted op keeps busy for WIDTH+1 cycles, result appears in the last.
    always @(posedge clk) begin
        if (reset) begin
            m_rem = 0; m_sum = 0; m_cout = 0; m_ovf = 0;
        end else if (m_rem == 0) begin
            if (start) begin
                ref_calc(8, longint'(A), longint'(B), sub, Cin, mr, mco, mov);
                p_sum = mr[7:0]; p_cout = mco; p_ovf = mov;
                m_rem = 9;
            end
        end else begin
            m_rem--;
            if (m_rem == 1) begin
                m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_rem != 0);
            chk("done", done, m_rem == 1);
            chk("sum", sum, m_sum);
            chk("cout", Cout, m_cout);
            chk("ovf", ovf, m_ovf);
        end
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c,
                        input logic [7:0] es, input logic ec, input logic eo, input string nm);
        int n, nb;
        @(negedge clk);
        A = a; B = b; sub = s; Cin = c; start = 1;
        @(negedge clk);
        start = 0;
        n = 1; nb = int'(busy);
        while (!done && n < 30) begin
            @(negedge clk);
            n++; nb += int'(busy);
        end
        chk({nm, " latency"}, n, 9);
        chk({nm, " busy cycles"}, nb, 9);
        chk({nm, " sum"}, sum, es);
        chk({nm, " cout"}, Cout, ec);
        chk({nm, " ovf"}, ovf, eo);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s, input logic c,
                        input logic [3:0] es, input logic ec, input logic eo, input string nm);
        int n;
        @(negedge clk);
        a4 = a; b4 = b; sub4 = s; cin4 = c; start4 = 1;
        @(negedge clk);
        start4 = 0;
        n = 1;
        while (!done4 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, n, 5);
        chk({nm, " sum"}, sum4, es);
        chk({nm, " cout"}, cout4, ec);
        chk({nm, " ovf"}, ovf4, eo);
        @(negedge clk);
        chk({nm, " idle"}, busy4, 0);
    endtask

    initial begin
        longint r;
        bit co, ov;
        int n, d1, d2;
        ref_calc(8, 'h3C, 'h0F, 0, 0, r, co, ov);
        chk("model add", {r[7:0], co, ov}, {8'h4B, 1'b0, 1'b0});
        ref_calc(8, 'h80, 'h01, 1, 0, r, co, ov);
        chk("model sub", {r[7:0], co, ov}, {8'h7F, 1'b1, 1'b1});
        ref_calc(8, 'h05, 'h07, 1, 0, r, co, ov);
        chk("model borrow", {r[7:0], co, ov}, {8'hFE, 1'b0, 1'b0});
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset sum", sum, 0);
        chk("reset cout/ovf", {Cout, ovf}, 0);
        chk_en = 1;
        reset = 0;
        run8(8'h3C, 8'h0F, 0, 0, 8'h4B, 0, 0, "add");
        run8(8'hFF, 8'h01, 0, 1, 8'h01, 1, 0, "add wrap");
        run8(8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, "add ovf");
        run8(8'h05, 8'h07, 1, 0, 8'hFE, 0, 0, "sub borrow");
        run8(8'h80, 8'h01, 1, 0, 8'h7F, 1, 1, "sub ovf");
        run8(8'h10, 8'h0F, 1, 1, 8'h00, 1, 0, "sub cin");
        // start pulses mid-operation and in the done cycle are ignored
        @(negedge clk);
        A = 8'h3C; B = 8'h0F; sub = 0; Cin = 0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        A = 8'hAA; start = 1;
        @(negedge clk);
        start = 0;
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("hs result", sum, 8'h4B);
        A = 8'hAA; B = 8'hAA; start = 1;
        @(negedge clk);
        start = 0;
        chk("hs done-cycle ignored", busy, 0);
        chk("hs held result", sum, 8'h4B);
        // start held high: back-to-back operations
        @(negedge clk);
        A = 8'h12; B = 8'h34; sub = 0; Cin = 0; start = 1;
        d1 = -1; d2 = -1;
        for (int t = 0; t < 40 && d2 < 0; t++) begin
            @(negedge clk);
            if (done) begin
                if (d1 < 0) d1 = t;
                else d2 = t;
            end
        end
        start = 0;
        chk("b2b spacing", d2 - d1, 10);
        chk("b2b sum", sum, 8'h46);
        // reset on the 4th shift cycle
        @(negedge clk);
        @(negedge clk);
        A = 8'h55; B = 8'h22; start = 1;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("abort busy", busy, 0);
        chk("abort sum", sum, 0);
        chk("abort cout/ovf", {Cout, ovf}, 0);
        repeat (12) @(negedge clk);
        run8(8'h01, 8'h02, 0, 0, 8'h03, 0, 0, "after abort");
        // random traffic with inputs changing every cycle
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            A = 8'($urandom); B = 8'($urandom);
            sub = 1'($urandom); Cin = 1'($urandom);
            start = ($urandom % 3) != 0;
            reset = ($urandom % 97) == 0;
        end
        @(negedge clk);
        reset = 0; start = 0;
        repeat (12) @(negedge clk);
        run4(4'h9, 4'h8, 0, 0, 4'h1, 1, 1, "w4 add");
        for (int i = 0; i < 24; i++) begin
            logic [3:0] ra, rb;
            logic rs, rc;
            ra = 4'($urandom); rb = 4'($urandom); rs = 1'($urandom); rc = 1'($urandom);
            ref_calc(4, longint'(ra), longint'(rb), rs, rc, r, co, ov);
            run4(ra, rb, rs, rc, r[3:0], co, ov, "w4 rand");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
